hex_mem_viewer: RTL and testbench

- Board-side memory inspector for the FPGA top level.
- Once the CPU halts, it fetches the word at a switch-selected address through a ready/enable handshake and shows it on DIGITS seven-segment displays.
- Debounced keys load a new address from the switches or step the address by STRIDE.
- Fetch timeouts are flagged.
- Successor to the fixed 8-digit combinational display mapping: width and depth are parametrised, and addressing is sequential with a handshake.

---
 rtl/hex_mem_viewer_if.sv | 15 +
 rtl/hex_mem_viewer.sv | 179 +++++++++++++++++
 tb/tb_hex_mem_viewer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_mem_viewer_if.sv
// Read-port bundle between the hex viewer and the system memory port.
interface hex_mem_viewer_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
);
   logic              mem_ren;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_load;

   // Viewer side issues requests
   modport master (output mem_ren, output mem_addr, input mem_ready, input mem_load);
   // Memory side answers them
   modport slave  (input mem_ren, input mem_addr, output mem_ready, output mem_load);
endinterface

// File: rtl/hex_mem_viewer.sv
// Board-side memory inspector: while the CPU is halted, fetch one word over a
// ready/enable handshake and show it on DIGITS active-low seven-segment digits.
// Debounced keys reload the address from the switches or step it by STRIDE.
// Optional build macro HEX_LZ_BLANK_EN: leading-zero blanking, and an "E" on
// digit 0 (all others blank) while err is set.
module hex_mem_viewer #(
   parameter int unsigned DIGITS          = 8,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned STRIDE          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  halt_i,
   input  logic [ADDR_W-1:0]     sw_addr,
   input  logic                  key_load_n,
   input  logic                  key_next_n,
   hex_mem_viewer_if.master      mem,
   output logic [7*DIGITS-1:0]   hex_seg,
   output logic                  busy,
   output logic                  err
);
   localparam int unsigned DATA_W = 4 * DIGITS;
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] disp_q, disp_d;
   logic              err_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              ren_q;

   // Index 0 = load key, index 1 = next key
   logic [1:0]        key_raw;
   logic [1:0]        sync1_q, sync2_q, db_q, press_q;
   logic [DB_W-1:0]   db_cnt_q [2];
   logic              load_p, next_p;

   assign key_raw = {key_next_n, key_load_n};
   assign load_p  = press_q[0];
   assign next_p  = press_q[1];

   // Synchronize, debounce and edge-detect both keys; pulse only on press
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= '1;
         sync2_q <= '1;
         db_q    <= '1;
         press_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
         press_q <= '0;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_q[i]     <= sync2_q[i];
               db_cnt_q[i] <= '0;
               press_q[i]  <= ~sync2_q[i];
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Next-state logic: fetch on halt, refetch on key pulses, time out stalled reads
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      disp_d   = disp_q;
      err_d    = err;
      to_cnt_d = '0;
      unique case (state_q)
         IDLE: begin
            if (halt_i) state_d = FETCH;
         end
         FETCH: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (mem.mem_ready) begin
               disp_d  = mem.mem_load;
               err_d   = 1'b0;
               state_d = halt_i ? SHOW : IDLE;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = halt_i ? SHOW : IDLE;
            end
         end
         SHOW: begin
            if (!halt_i) begin
               state_d = IDLE;
            end else if (load_p) begin
               addr_d  = sw_addr;
               state_d = FETCH;
            end else if (next_p) begin
               addr_d  = addr_q + ADDR_W'(STRIDE);
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         disp_q   <= '0;
         err      <= 1'b0;
         to_cnt_q <= '0;
         ren_q    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         disp_q   <= disp_d;
         err      <= err_d;
         to_cnt_q <= to_cnt_d;
         ren_q    <= (state_d == FETCH);
         busy     <= (state_d == FETCH);
      end
   end

   assign mem.mem_ren  = ren_q;
   assign mem.mem_addr = addr_q;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b0100111;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

`ifdef HEX_LZ_BLANK_EN
   logic lz_seen;

   // Decode digits, blanking zeros above the most significant nonzero nibble
   always_comb begin
      hex_seg = '1;
      lz_seen = 1'b0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         if (disp_q[4*k +: 4] != 4'h0) lz_seen = 1'b1;
         if (lz_seen || k == 0) hex_seg[7*k +: 7] = seg7(disp_q[4*k +: 4]);
      end
      if (err) begin
         hex_seg      = '1;
         hex_seg[6:0] = 7'b0000110;
      end
   end
`else
   // Decode every nibble of the held display word
   always_comb begin
      hex_seg = '1;
      for (int k = 0; k < int'(DIGITS); k++) hex_seg[7*k +: 7] = seg7(disp_q[4*k +: 4]);
   end
`endif

endmodule

// File: tb/tb_hex_mem_viewer.sv
// Directed bench for hex_mem_viewer with short debounce/timeout settings.
module tb_hex_mem_viewer;
   localparam int unsigned DIGITS = 8;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRIDE = 4;
   localparam int unsigned DEB    = 8;
   localparam int unsigned TMO    = 16;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              halt_i = 1'b0;
   logic [ADDR_W-1:0] sw_addr = '0;
   logic              key_load_n = 1'b1;
   logic              key_next_n = 1'b1;
   logic [7*DIGITS-1:0] hex_seg;
   logic              busy, err;

   int n_checks = 0;
   int n_fail   = 0;

   hex_mem_viewer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

   hex_mem_viewer #(
      .DIGITS(DIGITS), .ADDR_W(ADDR_W), .STRIDE(STRIDE),
      .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(CLK), .RST(RST), .halt_i(halt_i), .sw_addr(sw_addr),
      .key_load_n(key_load_n), .key_next_n(key_next_n),
      .mem(mem_bus), .hex_seg(hex_seg), .busy(busy), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_ref(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[n];
   endfunction

   function automatic logic [55:0] exp_hex(input logic [31:0] v, input logic e);
      logic [55:0] r;
      int top;
      r = '1;
`ifdef HEX_LZ_BLANK_EN
      if (e) begin
         r[6:0] = 7'b0000110;
         return r;
      end
      top = 0;
      for (int k = 0; k < 8; k++) if (v[4*k +: 4] != 4'h0) top = k;
      for (int k = 0; k <= top; k++) r[7*k +: 7] = seg_ref(v[4*k +: 4]);
`else
      top = int'(e);
      for (int k = 0; k < 8; k++) r[7*k +: 7] = seg_ref(v[4*k +: 4]);
`endif
      return r;
   endfunction

   // Wait (bounded) for a read request and check its address
   task automatic wait_fetch(input logic [15:0] exp_addr, input string tag, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge CLK);
         if (mem_bus.mem_ren) seen = 1'b1;
      end
      check({tag, "_start"}, 64'(seen), 64'd1);
      if (seen) begin
         check({tag, "_addr"}, 64'(mem_bus.mem_addr), 64'(exp_addr));
         check({tag, "_busy"}, 64'(busy), 64'd1);
      end
   endtask

   // Answer a request after two wait cycles, then check the handshake closed
   task automatic fetch_respond(input logic [15:0] exp_addr, input logic [31:0] data, input string tag);
      bit seen;
      bit ren_ok;
      wait_fetch(exp_addr, tag, seen);
      if (!seen) return;
      ren_ok = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         if (!mem_bus.mem_ren) ren_ok = 1'b0;
      end
      mem_bus.mem_ready = 1'b1;
      mem_bus.mem_load  = data;
      @(negedge CLK);
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_load  = 32'h0;
      check({tag, "_ren_held"}, 64'(ren_ok), 64'd1);
      check({tag, "_ren_drop"}, 64'(mem_bus.mem_ren), 64'd0);
      check({tag, "_busy_drop"}, 64'(busy), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_hex"}, 64'(hex_seg), 64'(exp_hex(data, 1'b0)));
   endtask

   task automatic release_keys();
      key_load_n = 1'b1;
      key_next_n = 1'b1;
      repeat (DEB + 6) @(negedge CLK);
   endtask

   initial begin
      bit seen;
      int cnt;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_load  = 32'h0;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_ren", 64'(mem_bus.mem_ren), 64'd0);
      check("rst_addr", 64'(mem_bus.mem_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_hex", 64'(hex_seg), 64'(exp_hex(32'h0, 1'b0)));
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      check("idle_no_fetch", 64'(mem_bus.mem_ren), 64'd0);

      // First fetch on halt
      halt_i = 1'b1;
      fetch_respond(16'h0000, 32'h1234ABCD, "first");
`ifndef HEX_LZ_BLANK_EN
      check("first_digits", 64'(hex_seg),
            64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0001000, 7'b0000011, 7'b0100111, 7'b0100001}));
`endif

      // Ready outside FETCH is ignored
      mem_bus.mem_ready = 1'b1;
      mem_bus.mem_load  = 32'h5555_5555;
      @(negedge CLK);
      mem_bus.mem_ready = 1'b0;
      @(negedge CLK);
      check("stray_ready_hex", 64'(hex_seg), 64'(exp_hex(32'h1234ABCD, 1'b0)));

      // Three-cycle glitch must not start a fetch
      sw_addr = 16'h0040;
      key_load_n = 1'b0;
      repeat (3) @(negedge CLK);
      key_load_n = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(negedge CLK);
         if (mem_bus.mem_ren) seen = 1'b1;
      end
      check("glitch_no_fetch", 64'(seen), 64'd0);

      // Debounced load press
      key_load_n = 1'b0;
      fetch_respond(16'h0040, 32'hDEADBEEF, "load");
      release_keys();

      // Step past the top of the address space
      sw_addr = 16'hFFFC;
      key_load_n = 1'b0;
      fetch_respond(16'hFFFC, 32'h000000F0, "load_top");
      release_keys();
      key_next_n = 1'b0;
      fetch_respond(16'h0000, 32'h00000005, "next_wrap");
      release_keys();

      // Simultaneous presses: load wins
      sw_addr = 16'h0010;
      key_load_n = 1'b0;
      fetch_respond(16'h0010, 32'h00ABC000, "load_10");
      release_keys();
      sw_addr = 16'h0100;
      key_load_n = 1'b0;
      key_next_n = 1'b0;
      fetch_respond(16'h0100, 32'h0000FACE, "both");
      release_keys();

      // Timeout with ready held low; junk on the data bus must not land
      mem_bus.mem_load = 32'hFFFF_FFFF;
      sw_addr = 16'h0200;
      key_load_n = 1'b0;
      wait_fetch(16'h0200, "tmo", seen);
      cnt = seen ? 1 : 0;
      for (int i = 0; i < 40 && seen && mem_bus.mem_ren; i++) begin
         @(negedge CLK);
         if (mem_bus.mem_ren) cnt++;
      end
      check("tmo_cycles", 64'(cnt), 64'(TMO));
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_busy", 64'(busy), 64'd0);
      check("tmo_hex", 64'(hex_seg), 64'(exp_hex(32'h0000FACE, 1'b1)));
      mem_bus.mem_load = 32'h0;
      release_keys();

      // Halt dropped: display held, no requests
      halt_i = 1'b0;
      repeat (4) @(negedge CLK);
      check("unhalt_ren", 64'(mem_bus.mem_ren), 64'd0);
      check("unhalt_hex", 64'(hex_seg), 64'(exp_hex(32'h0000FACE, 1'b1)));
      halt_i = 1'b1;
      fetch_respond(16'h0200, 32'h13579BDF, "rehalt");

      // Reset in the middle of a fetch
      sw_addr = 16'h0300;
      key_load_n = 1'b0;
      wait_fetch(16'h0300, "pre_rst", seen);
      RST = 1'b1;
      #1;
      check("rst_mid_ren", 64'(mem_bus.mem_ren), 64'd0);
      check("rst_mid_hex", 64'(hex_seg), 64'(exp_hex(32'h0, 1'b0)));
      key_load_n = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      fetch_respond(16'h0000, 32'hCAFE0001, "post_rst");

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
